// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the alignment rule used to reject accesses before they touch memory.
package load_store_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } lsu_state_t;

  // Size 2'b11 is reserved and always rejected alongside true misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) ||
           ((size == SZ_WORD) && (lane != 2'b00)) ||
           (size == 2'b11);
  endfunction

endpackage

// File: rtl/load_store_unit_lane_merge.sv
// Byte-lane helper: with extract=0 it inserts right-aligned store data into a
// memory word; with extract=1 it pulls a lane out and sign/zero extends it.
module lane_merge (
  input  logic        extract,
  input  logic        sign_ext,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] result
);
  import load_store_unit_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = old_word[7:0];
      2'd1:    byte_sel = old_word[15:8];
      2'd2:    byte_sel = old_word[23:16];
      default: byte_sel = old_word[31:24];
    endcase
    half_sel = lane[1] ? old_word[31:16] : old_word[15:0];
  end

  always_comb begin
    result = old_word;
    if (extract) begin
      case (size)
        SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
        default: result = old_word;
      endcase
    end else begin
      case (size)
        SZ_BYTE: begin
          case (lane)
            2'd0:    result[7:0]   = wdata[7:0];
            2'd1:    result[15:8]  = wdata[7:0];
            2'd2:    result[23:16] = wdata[7:0];
            default: result[31:24] = wdata[7:0];
          endcase
        end
        SZ_HALF: begin
          if (lane[1]) result[31:16] = wdata[15:0];
          else         result[15:0]  = wdata[15:0];
        end
        default: result = wdata;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-addressed memory without byte
// enables; sub-word stores are done as a two-cycle read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W+1:0] byteAddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              memWE,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDataIn,
  input  logic [DATA_W-1:0] memDataOut,
  output logic              state_dbg
);
  import load_store_unit_pkg::*;

  // Handshake: a request is taken on a posedge where req=1 and ready=1; each
  // taken request produces exactly one done pulse, with err valid alongside it.

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] merged_q;

  logic [1:0]        lane;
  logic              misaligned;
  logic              word_store;
  logic [31:0]       lane_result;

  assign lane       = byteAddr[1:0];
  assign misaligned = is_misaligned(size, lane);
  assign word_store = (state == IDLE) && req && we && !misaligned && (size == SZ_WORD);
  assign ready      = (state == IDLE);
  assign state_dbg  = state;

  // One helper serves both directions: loads extract, stores merge.
  lane_merge u_lane_merge (
    .extract  (~we),
    .sign_ext (signExt),
    .size     (size),
    .lane     (lane),
    .old_word (memDataOut),
    .wdata    (wdata),
    .result   (lane_result)
  );

  always_comb begin
    memWE     = 1'b0;
    memAddr   = byteAddr[ADDR_W+1:2];
    memDataIn = '0;
    if (state == MERGE_WR) begin
      memWE     = 1'b1;
      memAddr   = addr_q;
      memDataIn = merged_q;
    end else if (word_store) begin
      memWE     = 1'b1;
      memDataIn = wdata;
    end
    // A reset landing mid-write must not let the pending write reach memory.
    if (!rstN) memWE = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      addr_q   <= '0;
      merged_q <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (misaligned) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (!we) begin
              rdata <= lane_result;
              done  <= 1'b1;
            end else if (size == SZ_WORD) begin
              done <= 1'b1;
            end else begin
              addr_q   <= byteAddr[ADDR_W+1:2];
              merged_q <= lane_result;
              state    <= MERGE_WR;
            end
          end
        end
        MERGE_WR: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference memory, expected-response
// queue drained by a done monitor, directed cases then random traffic.
module tb_load_store_unit;

  localparam int W = 33;

  logic        clk;
  logic        rstN;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        signExt;
  logic [11:0] byteAddr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        memWE;
  logic [9:0]  memAddr;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;
  logic        state_dbg;

  logic [31:0] mem [1024] = '{default: 32'h0};
  logic        poke_en;
  logic [9:0]  poke_addr;
  logic [31:0] poke_data;

  logic [7:0]  ref_b [4096] = '{default: 8'h00};
  logic [31:0] last_rdata;
  logic [W-1:0] exp_q[$];

  int checks;
  int errors;
  int we_cnt;
  int busy_cnt;
  int done_cnt;
  logic [9:0] last_we_addr;

  load_store_unit dut (
    .clk        (clk),
    .rstN       (rstN),
    .req        (req),
    .we         (we),
    .size       (size),
    .signExt    (signExt),
    .byteAddr   (byteAddr),
    .wdata      (wdata),
    .ready      (ready),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .memWE      (memWE),
    .memAddr    (memAddr),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memDataOut = mem[memAddr];

  always @(posedge clk) begin
    if (memWE) mem[memAddr] <= memDataIn;
    else if (poke_en) mem[poke_addr] <= poke_data;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Reference: memory as bytes, aligned means address is a multiple of the size.
  task automatic model_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [11:0] a, input logic [31:0] d);
    int nbytes;
    logic [31:0] v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || (int'(a) % nbytes) != 0) begin
      exp_q.push_back({1'b1, last_rdata});
    end else if (w) begin
      for (int i = 0; i < nbytes; i++) ref_b[int'(a) + i] = d[8*i +: 8];
      exp_q.push_back({1'b0, last_rdata});
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v[8*i +: 8] = ref_b[int'(a) + i];
      if (sx && nbytes < 4 && v[8*nbytes-1]) v = v | ~((32'h1 << (8*nbytes)) - 32'h1);
      last_rdata = v;
      exp_q.push_back({1'b0, v});
    end
  endtask

  // Called at a negedge; returns at the negedge after the request was taken.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [11:0] a, input logic [31:0] d);
    int n;
    n = 0;
    req = 1'b1; we = w; size = sz; signExt = sx; byteAddr = a; wdata = d;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      check("ready_timeout", {31'h0, ready}, 32'h1);
      req = 1'b0;
    end else begin
      model_access(w, sz, sx, a, d);
      @(negedge clk);
    end
  endtask

  task automatic idle_cycles(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int w, input logic [31:0] val);
    poke_addr = 10'(w); poke_data = val; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*w + i] = val[8*i +: 8];
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (memWE) begin
      we_cnt++;
      last_we_addr = memAddr;
    end
    if (!ready) busy_cnt++;
    if (rstN && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending access");
      end else begin
        e = exp_q.pop_front();
        check("done_err", {31'h0, err}, {31'h0, e[32]});
        check("done_rdata", rdata, e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int w0, b0, d0, n, bad;
    logic [31:0] r0;
    checks = 0; errors = 0; we_cnt = 0; busy_cnt = 0; done_cnt = 0;
    last_rdata = 32'h0; last_we_addr = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    rstN = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; signExt = 1'b0;
    byteAddr = '0; wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, ready}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_memwe", {31'h0, memWE}, 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    // word store then word load
    w0 = we_cnt;
    issue(1'b1, 2'd2, 1'b0, 12'h008, 32'hDEADBEEF);
    idle_cycles(2);
    check("wstore_we_cycles", 32'(we_cnt - w0), 32'd1);
    check("wstore_addr", {22'h0, last_we_addr}, 32'd2);
    issue(1'b0, 2'd2, 1'b0, 12'h008, 32'h0);
    check("wload_latency", {31'h0, done}, 32'h1);
    idle_cycles(2);
    check("wload_rdata", rdata, 32'hDEADBEEF);

    // byte read-modify-write
    poke(2, 32'h11223344);
    w0 = we_cnt; b0 = busy_cnt;
    issue(1'b1, 2'd0, 1'b0, 12'h00A, 32'h123456AA);
    idle_cycles(3);
    check("byte_rmw_busy", 32'(busy_cnt - b0), 32'd1);
    check("byte_rmw_we_cycles", 32'(we_cnt - w0), 32'd1);
    check("byte_rmw_mem", mem[2], 32'h11AA3344);
    issue(1'b0, 2'd0, 1'b1, 12'h00A, 32'h0);
    idle_cycles(1);
    check("byte_load_sext", rdata, 32'hFFFFFFAA);
    issue(1'b0, 2'd0, 1'b0, 12'h00A, 32'h0);
    idle_cycles(1);
    check("byte_load_zext", rdata, 32'h000000AA);

    // halfword store / signed load
    poke(3, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 12'h00E, 32'hFFFF8001);
    idle_cycles(3);
    check("half_rmw_mem", mem[3], 32'h80010000);
    issue(1'b0, 2'd1, 1'b1, 12'h00E, 32'h0);
    idle_cycles(1);
    check("half_load_sext", rdata, 32'hFFFF8001);

    // misaligned accesses
    r0 = rdata; w0 = we_cnt;
    issue(1'b1, 2'd1, 1'b0, 12'h005, 32'h0000BEEF);
    issue(1'b0, 2'd2, 1'b0, 12'h006, 32'h0);
    idle_cycles(2);
    check("misalign_no_we", 32'(we_cnt - w0), 32'd0);
    check("misalign_rdata_held", rdata, r0);
    check("misalign_mem1", mem[1], ref_word(1));

    // back-to-back with one sub-word store in the stream
    b0 = busy_cnt; d0 = done_cnt;
    issue(1'b0, 2'd2, 1'b0, 12'h008, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 12'h00C, 32'hA5A5A5A5);
    issue(1'b1, 2'd0, 1'b0, 12'h010, 32'h0000005A);
    issue(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    idle_cycles(3);
    check("b2b_busy", 32'(busy_cnt - b0), 32'd1);
    check("b2b_dones", 32'(done_cnt - d0), 32'd4);
    check("b2b_rdata", rdata, 32'h0000005A);

    // reset while the merge write is pending
    poke(5, 32'hCAFEF00D);
    req = 1'b1; we = 1'b1; size = 2'd0; signExt = 1'b0; byteAddr = 12'h014; wdata = 32'h77;
    @(negedge clk);
    check("rmw_pending", {31'h0, ready}, 32'h0);
    req = 1'b0;
    #2 rstN = 1'b0;
    #1;
    check("rst_mid_memwe", {31'h0, memWE}, 32'h0);
    check("rst_mid_ready", {31'h0, ready}, 32'h1);
    @(negedge clk);
    rstN = 1'b1;
    last_rdata = 32'h0;
    idle_cycles(2);
    check("rst_mid_mem", mem[5], 32'hCAFEF00D);
    check("rst_mid_done", {31'h0, done}, 32'h0);
    check("rst_mid_ready_after", {31'h0, ready}, 32'h1);

    // random traffic over a small window to force reuse of the same words
    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    n = 0;
    req = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_word(i)) bad++;
    check("final_mem_words_bad", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
